// File: rtl/denovo_pkg.sv
// Shared types and the MinHash hash function for the de novo similarity engines.
// Pure package: no state, no latency, no flow control.
// Hash results are widened to 32 bits; callers keep the low HASH_W bits.
package denovo_pkg;

    localparam int DEF_KMER_W = 6;
    localparam int DEF_HASH_W = 6;

    typedef enum logic [1:0] {
        ST_ACCUM   = 2'd0,
        ST_COMPARE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    // Full 64-bit product and sum, then reduction mod 2^hash_w (hash_w <= 32).
    function automatic logic [31:0] minhash_h(
        input logic [31:0] a,
        input logic [31:0] b,
        input logic [31:0] x,
        input int unsigned hash_w
    );
        logic [63:0] full;
        logic [63:0] mask;
        full = ({32'd0, a} * {32'd0, x}) + {32'd0, b};
        mask = (64'd1 << hash_w) - 64'd1;
        return 32'(full & mask);
    endfunction

endpackage

// File: rtl/minhash_lane.sv
// One MinHash lane: coefficient registers, hash datapath, running minima for sides A and B.
// Minima update on the edge that accepts the beat; eq is combinational from the registered minima.
// No backpressure of its own; the parent gates cfg_we/upd_*/clr.
module minhash_lane
    import denovo_pkg::*;
#(
    parameter int KMER_W = DEF_KMER_W,
    parameter int HASH_W = DEF_HASH_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [KMER_W-1:0] cfg_a,
    input  logic [KMER_W-1:0] cfg_b,
    input  logic              clr,
    input  logic              upd_a,
    input  logic              upd_b,
    input  logic [KMER_W-1:0] kmer_a,
    input  logic [KMER_W-1:0] kmer_b,
    output logic              eq
);

    logic [KMER_W-1:0] coef_a_q, coef_a_d;
    logic [KMER_W-1:0] coef_b_q, coef_b_d;
    logic [HASH_W-1:0] min_a_q, min_a_d;
    logic [HASH_W-1:0] min_b_q, min_b_d;
    logic [31:0]       h_a_full, h_b_full;
    logic [HASH_W-1:0] h_a, h_b;
    logic              unused_hi;

    always_comb begin
        h_a_full = minhash_h(32'(coef_a_q), 32'(coef_b_q), 32'(kmer_a), HASH_W);
        h_b_full = minhash_h(32'(coef_a_q), 32'(coef_b_q), 32'(kmer_b), HASH_W);
        h_a      = h_a_full[HASH_W-1:0];
        h_b      = h_b_full[HASH_W-1:0];
    end

    // Upper hash bits are already masked to zero by minhash_h.
    assign unused_hi = ^{h_a_full[31:HASH_W], h_b_full[31:HASH_W]};

    always_comb begin
        coef_a_d = coef_a_q;
        coef_b_d = coef_b_q;
        min_a_d  = min_a_q;
        min_b_d  = min_b_q;
        if (cfg_we) begin
            coef_a_d = cfg_a;
            coef_b_d = cfg_b;
        end
        if (clr) begin
            min_a_d = '1;
            min_b_d = '1;
        end else begin
            if (upd_a && (h_a < min_a_q)) min_a_d = h_a;
            if (upd_b && (h_b < min_b_q)) min_b_d = h_b;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coef_a_q <= KMER_W'(1);
            coef_b_q <= '0;
            min_a_q  <= '1;
            min_b_q  <= '1;
        end else begin
            coef_a_q <= coef_a_d;
            coef_b_q <= coef_b_d;
            min_a_q  <= min_a_d;
            min_b_q  <= min_b_d;
        end
    end

    assign eq = (min_a_q == min_b_q);

endmodule

// File: rtl/minhash_jaccard_engine.sv
// Streaming MinHash Jaccard estimator: per-lane minima over a frame, lane-agreement count on in_last.
// Latency: last beat accepted at edge E0, out_valid high after E0+1 (one COMPARE cycle).
// Backpressure: in_ready low from COMPARE until the result handshake; result held while out_ready=0.
module minhash_jaccard_engine
    import denovo_pkg::*;
#(
    parameter int KMER_W     = 6,
    parameter int HASH_W     = 6,
    parameter int NUM_HASHES = 4,
    parameter int CNT_W      = 16,
    localparam int IDX_W     = (NUM_HASHES > 1) ? $clog2(NUM_HASHES) : 1,
    localparam int MC_W      = $clog2(NUM_HASHES + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [KMER_W-1:0] cfg_a,
    input  logic [KMER_W-1:0] cfg_b,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_en_a,
    input  logic              in_en_b,
    input  logic [KMER_W-1:0] in_kmer_a,
    input  logic [KMER_W-1:0] in_kmer_b,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MC_W-1:0]   out_match_count,
    output logic              out_empty,
    output logic [CNT_W-1:0]  out_cnt_a,
    output logic [CNT_W-1:0]  out_cnt_b
);

    state_t            state_q, state_d;
    logic              frame_active_q, frame_active_d;
    logic [CNT_W-1:0]  cnt_a_q, cnt_a_d;
    logic [CNT_W-1:0]  cnt_b_q, cnt_b_d;
    logic [CNT_W-1:0]  res_cnt_a_q, res_cnt_a_d;
    logic [CNT_W-1:0]  res_cnt_b_q, res_cnt_b_d;
    logic [MC_W-1:0]   match_q, match_d;
    logic              empty_q, empty_d;

    logic              accept;
    logic              cfg_ok;
    logic              lane_clr;
    logic              upd_a, upd_b;
    logic [NUM_HASHES-1:0] lane_eq;
    logic [MC_W-1:0]   eq_pop;

    assign in_ready  = (state_q == ST_ACCUM);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;

    // Coefficients are frozen from the first beat of a frame until its result is taken.
    assign cfg_ok = cfg_we && (state_q == ST_ACCUM) && !frame_active_q && !accept;

    // Out-of-range cfg_idx matches no lane, so such writes fall through.
    for (genvar i = 0; i < NUM_HASHES; i++) begin : g_lane
        minhash_lane #(
            .KMER_W (KMER_W),
            .HASH_W (HASH_W)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .cfg_we (cfg_ok && (cfg_idx == IDX_W'(i))),
            .cfg_a  (cfg_a),
            .cfg_b  (cfg_b),
            .clr    (lane_clr),
            .upd_a  (upd_a),
            .upd_b  (upd_b),
            .kmer_a (in_kmer_a),
            .kmer_b (in_kmer_b),
            .eq     (lane_eq[i])
        );
    end

    always_comb begin
        eq_pop = '0;
        for (int i = 0; i < NUM_HASHES; i++) begin
            eq_pop = eq_pop + MC_W'(lane_eq[i]);
        end
    end

    always_comb begin
        state_d        = state_q;
        frame_active_d = frame_active_q;
        cnt_a_d        = cnt_a_q;
        cnt_b_d        = cnt_b_q;
        res_cnt_a_d    = res_cnt_a_q;
        res_cnt_b_d    = res_cnt_b_q;
        match_d        = match_q;
        empty_d        = empty_q;
        upd_a          = 1'b0;
        upd_b          = 1'b0;
        lane_clr       = 1'b0;
        case (state_q)
            ST_ACCUM: begin
                if (accept) begin
                    frame_active_d = 1'b1;
                    upd_a          = in_en_a;
                    upd_b          = in_en_b;
                    if (in_en_a && !(&cnt_a_q)) cnt_a_d = cnt_a_q + CNT_W'(1);
                    if (in_en_b && !(&cnt_b_q)) cnt_b_d = cnt_b_q + CNT_W'(1);
                    if (in_last) state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                // Untouched minima on an empty side would compare equal, hence the override.
                empty_d     = (cnt_a_q == '0) || (cnt_b_q == '0);
                match_d     = empty_d ? '0 : eq_pop;
                res_cnt_a_d = cnt_a_q;
                res_cnt_b_d = cnt_b_q;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    lane_clr       = 1'b1;
                    cnt_a_d        = '0;
                    cnt_b_d        = '0;
                    frame_active_d = 1'b0;
                    state_d        = ST_ACCUM;
                end
            end
            default: state_d = ST_ACCUM;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_ACCUM;
            frame_active_q <= 1'b0;
            cnt_a_q        <= '0;
            cnt_b_q        <= '0;
            res_cnt_a_q    <= '0;
            res_cnt_b_q    <= '0;
            match_q        <= '0;
            empty_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            frame_active_q <= frame_active_d;
            cnt_a_q        <= cnt_a_d;
            cnt_b_q        <= cnt_b_d;
            res_cnt_a_q    <= res_cnt_a_d;
            res_cnt_b_q    <= res_cnt_b_d;
            match_q        <= match_d;
            empty_q        <= empty_d;
        end
    end

    assign out_match_count = match_q;
    assign out_empty       = empty_q;
    assign out_cnt_a       = res_cnt_a_q;
    assign out_cnt_b       = res_cnt_b_q;

endmodule

// File: tb/tb_minhash_jaccard_engine.sv
// Self-checking bench for minhash_jaccard_engine: frame table plus hand-written corner sequences.
module tb_minhash_jaccard_engine;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_idx = '0;
    logic [5:0] cfg_a = '0;
    logic [5:0] cfg_b = '0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       in_en_a = 1'b0;
    logic       in_en_b = 1'b0;
    logic [5:0] in_kmer_a = '0;
    logic [5:0] in_kmer_b = '0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [2:0] out_match_count;
    logic       out_empty;
    logic [15:0] out_cnt_a;
    logic [15:0] out_cnt_b;

    minhash_jaccard_engine #(
        .KMER_W(6), .HASH_W(6), .NUM_HASHES(4), .CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_a(cfg_a), .cfg_b(cfg_b),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_en_a(in_en_a), .in_en_b(in_en_b),
        .in_kmer_a(in_kmer_a), .in_kmer_b(in_kmer_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_match_count(out_match_count), .out_empty(out_empty),
        .out_cnt_a(out_cnt_a), .out_cnt_b(out_cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [7:0]  ea;
        logic [7:0]  eb;
        logic [47:0] ka;
        logic [47:0] kb;
        int          cset;
        int          mc;
        bit          em;
        int          ca;
        int          cb;
    } vec_t;

    typedef struct {
        int mc;
        bit em;
        int ca;
        int cb;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Frame used for config-lockout and reset checks: A={10,5,20,21}, B={10} on beat 0 only.
    vec_t frame_f;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic write_cfg(input int idx, input int a, input int b);
        cfg_we  = 1'b1;
        cfg_idx = 2'(idx);
        cfg_a   = 6'(a);
        cfg_b   = 6'(b);
        @(posedge clk); #1;
        cfg_we  = 1'b0;
    endtask

    task automatic set_cset(input int cset);
        if (cset == 0) begin
            write_cfg(0, 30, 15);
            write_cfg(1, 23, 10);
            write_cfg(2, 1, 0);
            write_cfg(3, 7, 3);
        end else begin
            for (int i = 0; i < 4; i++) write_cfg(i, 1, 0);
        end
    endtask

    // Beats flagged in cfg_mask also attempt a write of (7,3) to lane 0.
    task automatic send_frame(input vec_t v, input logic [7:0] cfg_mask);
        for (int j = 0; j < v.n; j++) begin
            in_valid  = 1'b1;
            in_en_a   = v.ea[j];
            in_en_b   = v.eb[j];
            in_kmer_a = v.ka[j*6 +: 6];
            in_kmer_b = v.kb[j*6 +: 6];
            in_last   = (j == v.n - 1);
            cfg_we    = cfg_mask[j];
            cfg_idx   = 2'd0;
            cfg_a     = 6'd7;
            cfg_b     = 6'd3;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_en_a  = 1'b0;
        in_en_b  = 1'b0;
        in_last  = 1'b0;
        cfg_we   = 1'b0;
        sb.push_back('{mc: v.mc, em: v.em, ca: v.ca, cb: v.cb});
    endtask

    task automatic collect(input string tag, input int hold, input bit cfg_hold);
        exp_t e;
        int   cyc = 0;
        while (!out_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        if (!out_valid) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: out_valid never rose within %0d cycles", tag, cyc);
            return;
        end
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_sb: result with empty scoreboard", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, cyc, 1);
        for (int h = 0; h < hold; h++) begin
            cfg_we  = cfg_hold;
            cfg_idx = 2'd0;
            cfg_a   = 6'd7;
            cfg_b   = 6'd3;
            @(posedge clk); #1;
            check($sformatf("%s_hold%0d_valid", tag, h), int'(out_valid), 1);
            check($sformatf("%s_hold%0d_inrdy", tag, h), int'(in_ready), 0);
            check($sformatf("%s_hold%0d_count", tag, h), int'(out_match_count), e.mc);
        end
        cfg_we = 1'b0;
        check({tag, "_count"}, int'(out_match_count), e.mc);
        check({tag, "_empty"}, int'(out_empty), int'(e.em));
        check({tag, "_cnt_a"}, int'(out_cnt_a), e.ca);
        check({tag, "_cnt_b"}, int'(out_cnt_b), e.cb);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, int'(out_valid), 0);
        check({tag, "_inrdy_back"}, int'(in_ready), 1);
    endtask

    initial begin
        //          n  ea     eb     ka                                    kb                                    cs mc em ca cb
        vecs[0] = '{4, 8'hF, 8'hF, {24'd0, 6'd21, 6'd20, 6'd5, 6'd10}, {24'd0, 6'd21, 6'd20, 6'd5, 6'd10}, 0, 4, 0, 4, 4};
        vecs[1] = '{4, 8'hF, 8'h1, {24'd0, 6'd21, 6'd20, 6'd5, 6'd10}, {42'd0, 6'd10},                    0, 1, 0, 4, 1};
        vecs[2] = '{1, 8'h1, 8'h1, {42'd0, 6'd1},                      {42'd0, 6'd2},                     1, 0, 0, 1, 1};
        vecs[3] = '{3, 8'h7, 8'h1, {30'd0, 6'd9, 6'd4, 6'd3},          {42'd0, 6'd3},                     1, 4, 0, 3, 1};
        vecs[4] = '{3, 8'h7, 8'h0, {30'd0, 6'd3, 6'd2, 6'd1},          48'd0,                             1, 0, 1, 3, 0};
        vecs[5] = '{3, 8'h5, 8'h5, {30'd0, 6'd2, 6'd0, 6'd7},          {30'd0, 6'd2, 6'd0, 6'd7},         1, 4, 0, 2, 2};
        vecs[6] = '{1, 8'h0, 8'h0, 48'd0,                              48'd0,                             1, 0, 1, 0, 0};
        frame_f = '{4, 8'hF, 8'h1, {24'd0, 6'd21, 6'd20, 6'd5, 6'd10}, {42'd0, 6'd10}, 1, 0, 0, 4, 1};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", int'(in_ready), 1);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_count", int'(out_match_count), 0);
        check("rst_empty", int'(out_empty), 0);
        check("rst_cnt_a", int'(out_cnt_a), 0);
        check("rst_cnt_b", int'(out_cnt_b), 0);

        for (int v = 0; v < 7; v++) begin
            set_cset(vecs[v].cset);
            send_frame(vecs[v], 8'h00);
            collect($sformatf("v%0d", v), 0, 1'b0);
        end

        // Lockout: writes on the first beat, mid-frame and during DONE are all ignored.
        set_cset(1);
        send_frame(frame_f, 8'h05);
        collect("lock", 5, 1'b1);
        send_frame(frame_f, 8'h00);
        collect("lock_after_done", 0, 1'b0);
        write_cfg(0, 7, 3);
        frame_f.mc = 1;
        send_frame(frame_f, 8'h00);
        collect("cfg_applied", 0, 1'b0);

        // Reset in the middle of a frame, with non-default coefficients loaded.
        set_cset(0);
        for (int j = 0; j < 2; j++) begin
            in_valid = 1'b1; in_en_a = 1'b1; in_en_b = 1'b1;
            in_kmer_a = 6'd1; in_kmer_b = 6'd2; in_last = 1'b0;
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_en_a = 1'b0; in_en_b = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_in_ready", int'(in_ready), 1);
        check("mid_rst_out_valid", int'(out_valid), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        frame_f.mc = 0;
        send_frame(frame_f, 8'h00);
        collect("post_rst_coef", 0, 1'b0);
        send_frame(vecs[0], 8'h00);
        collect("post_rst_ident", 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
